// File: rtl/div.sv
// Sequential signed divider for the HI/LO unit: restoring radix-2 on operand
// magnitudes, one quotient bit per RUN cycle, then a one-cycle sign fix-up.
module div #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  input  logic         divCtrl,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         done,
  output logic         busy,
  output logic         divZero
);

  // state | meaning
  // IDLE  | waiting for divCtrl; done/busy of the previous op retire here
  // RUN   | N restoring iterations, one quotient bit per cycle
  // FIX   | apply signs to quotient/remainder, pulse done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_next;

  logic [N:0]    dvd;
  logic [N:0]    dvs;
  logic [N:0]    rem;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;
  logic          sign_a;
  logic          sign_b;
  logic          zero_flag;

  logic [N:0] ext_a, ext_b, abs_a, abs_b;
  logic [N:0] rem_sh, rem_diff;
  logic       q_bit;
  logic       b_is_zero;

  // Magnitudes are taken in N+1 bits so that -2^(N-1) has a representable abs value.
  always_comb begin
    ext_a     = {srcA[N-1], srcA};
    ext_b     = {srcB[N-1], srcB};
    abs_a     = srcA[N-1] ? -ext_a : ext_a;
    abs_b     = srcB[N-1] ? -ext_b : ext_b;
    b_is_zero = (srcB == '0);
    rem_sh    = {rem[N-1:0], dvd[N-1]};
    rem_diff  = rem_sh - dvs;
    q_bit     = (rem_sh >= dvs);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (divCtrl) state_next = b_is_zero ? FIX : RUN;
      RUN:  if (cnt == LAST) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      zero_flag <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      divZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (divCtrl) begin
            dvd       <= abs_a;
            dvs       <= abs_b;
            sign_a    <= srcA[N-1];
            sign_b    <= srcB[N-1];
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            zero_flag <= b_is_zero;
            divZero   <= 1'b0;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          dvd <= {dvd[N-1:0], 1'b0};
          rem <= q_bit ? rem_diff : rem_sh;
          quo <= {quo[N-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          // busy stays high through the done cycle and falls in IDLE
          if (zero_flag) begin
            divZero <= 1'b1;
          end else begin
            lo <= (sign_a ^ sign_b) ? -quo : quo;
            hi <= sign_a ? -rem[N-1:0] : rem[N-1:0];
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div: results, latency, busy/done framing,
// divide-by-zero, overflow, mid-operation reset and ignored restarts.
module tb_div;

  logic        clk;
  logic        reset;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        divCtrl;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        busy;
  logic        divZero;

  int n_tests = 0;
  int n_fail  = 0;

  div #(.N(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .srcA    (srcA),
    .srcB    (srcB),
    .divCtrl (divCtrl),
    .hi      (hi),
    .lo      (lo),
    .done    (done),
    .busy    (busy),
    .divZero (divZero)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start one op, wait (bounded) for done, check latency, results and framing.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_dz, input int exp_lat, input bit disturb);
    int cyc;
    bit seen;
    @(negedge clk);
    srcA    = a;
    srcB    = b;
    divCtrl = 1'b1;
    @(posedge clk);
    #1 divCtrl = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
      if (disturb && cyc == 5) begin
        divCtrl = 1'b1;
        srcA    = 32'd12345;
        srcB    = 32'd1;
      end
      if (disturb && cyc == 6) divCtrl = 1'b0;
      if (done) seen = 1;
    end
    check({tag, " done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " divZero"}, {31'b0, divZero}, {31'b0, exp_dz});
    check({tag, " busy_in_done"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " busy_drop"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    reset   = 1'b0;
    srcA    = '0;
    srcB    = '0;
    divCtrl = 1'b0;
    repeat (3) @(negedge clk);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst flags", {29'b0, done, busy, divZero}, 32'd0);
    reset = 1'b1;

    do_div("780/30", 32'd780, 32'd30, 32'd26, 32'd0, 1'b0, 34, 0);
    do_div("-169/13", 32'hFFFF_FF57, 32'd13, 32'hFFFF_FFF3, 32'd0, 1'b0, 34, 0);
    do_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 0);
    do_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0);
    do_div("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 34, 0);
    do_div("785/30", 32'd785, 32'd30, 32'd26, 32'd5, 1'b0, 34, 0);
    do_div("div0", 32'd99, 32'd0, 32'd26, 32'd5, 1'b1, 2, 0);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 0);
    do_div("-1/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 0);
    do_div("max/16", 32'h7FFF_FFFF, 32'd16, 32'h07FF_FFFF, 32'd15, 1'b0, 34, 0);

    // abort 100/7 partway through RUN
    @(negedge clk);
    srcA    = 32'd100;
    srcB    = 32'd7;
    divCtrl = 1'b1;
    @(posedge clk);
    #1 divCtrl = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort no_done", n_done, 32'd0);

    do_div("100/7 restart", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1);
    repeat (3) @(negedge clk);
    check("ignored start idle", {30'b0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
